// File: rtl/bcd_counter_chain.sv
// Cascaded DIGITS-wide BCD up/down counter with load, enable and one-shot terminal count.
// Define BCD_COUNTER_MMSS_EN to make digits 1 and 3 mod-6 (mm:ss timer layout).
module bcd_counter_chain #(
    parameter int DIGITS        = 4,
    parameter bit HOLD_AT_LIMIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  zero
);

    function automatic logic [3:0] digit_max(input int idx);
`ifdef BCD_COUNTER_MMSS_EN
        return (idx == 1 || idx == 3) ? 4'd5 : 4'd9;
`else
        return (idx >= 0) ? 4'd9 : 4'd9;
`endif
    endfunction

    logic [4*DIGITS-1:0] count_reg;
    logic                tc_reg;
    // Set once the current limit has been flagged, so held steps there stay quiet.
    logic                expired_reg;

    logic [4*DIGITS-1:0] max_val;
    logic [4*DIGITS-1:0] step_next;
    logic [4*DIGITS-1:0] clamp_next;
    logic                at_limit;
    logic                lands_on_limit;
    logic                tc_next;
    logic                expired_next;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_max
            assign max_val[4*gi +: 4] = digit_max(gi);
        end
    endgenerate

    // Single-cycle ripple: each digit steps only when every lower digit is at its roll point.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] digit;
        logic [3:0] dmax;
        logic [3:0] ld;
        carry      = 1'b1;
        borrow     = 1'b1;
        digit      = '0;
        dmax       = '0;
        ld         = '0;
        step_next  = count_reg;
        clamp_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_reg[4*i +: 4];
            dmax  = max_val[4*i +: 4];
            ld    = load_val[4*i +: 4];
            if (up) begin
                if (carry) begin
                    step_next[4*i +: 4] = (digit == dmax) ? 4'd0 : digit + 4'd1;
                end
                carry = carry & (digit == dmax);
            end else begin
                if (borrow) begin
                    step_next[4*i +: 4] = (digit == 4'd0) ? dmax : digit - 4'd1;
                end
                borrow = borrow & (digit == 4'd0);
            end
            clamp_next[4*i +: 4] = (ld > dmax) ? dmax : ld;
        end
    end

    always_comb begin
        at_limit       = up ? (count_reg == max_val) : (count_reg == '0);
        lands_on_limit = up ? (step_next == max_val) : (step_next == '0);
        tc_next        = 1'b0;
        expired_next   = 1'b0;
        if (at_limit) begin
            tc_next      = HOLD_AT_LIMIT ? !expired_reg : 1'b1;
            expired_next = HOLD_AT_LIMIT;
        end else begin
            tc_next      = lands_on_limit;
            expired_next = HOLD_AT_LIMIT && lands_on_limit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            tc_reg      <= 1'b0;
            expired_reg <= 1'b0;
        end else if (load) begin
            count_reg   <= clamp_next;
            tc_reg      <= 1'b0;
            expired_reg <= 1'b0;
        end else if (en) begin
            if (!(HOLD_AT_LIMIT && at_limit)) begin
                count_reg <= step_next;
            end
            tc_reg      <= tc_next;
            expired_reg <= expired_next;
        end else begin
            tc_reg <= 1'b0;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Drives a holding and a wrapping 4-digit counter with the same vectors and checks both.
module tb_bcd_counter_chain;

    logic        clk = 1'b0;
    logic        reset, en, up, load;
    logic [15:0] load_val;
    logic [15:0] count_h, count_w;
    logic        tc_h, tc_w, zero_h, zero_w;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bcd_counter_chain #(.DIGITS(4), .HOLD_AT_LIMIT(1'b1)) dut_hold (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_h), .tc(tc_h), .zero(zero_h)
    );

    bcd_counter_chain #(.DIGITS(4), .HOLD_AT_LIMIT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .zero(zero_w)
    );

    typedef struct {
        logic        ld;
        logic        en;
        logic        up;
        logic [15:0] val;
        logic [15:0] hc;
        logic        ht;
        logic [15:0] wc;
        logic        wt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic l, input logic e, input logic u, input logic [15:0] v,
                       input logic [15:0] hc, input logic ht, input logic [15:0] wc, input logic wt);
        vec_t r;
        r.ld = l; r.en = e; r.up = u; r.val = v;
        r.hc = hc; r.ht = ht; r.wc = wc; r.wt = wt;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [15:0] hc, input logic ht,
                            input logic [15:0] wc, input logic wt);
        chk({tag, " hold count"}, count_h, hc);
        chk({tag, " hold tc"}, {15'd0, tc_h}, {15'd0, ht});
        chk({tag, " hold zero"}, {15'd0, zero_h}, {15'd0, (hc == 16'h0000)});
        chk({tag, " wrap count"}, count_w, wc);
        chk({tag, " wrap tc"}, {15'd0, tc_w}, {15'd0, wt});
        chk({tag, " wrap zero"}, {15'd0, zero_w}, {15'd0, (wc == 16'h0000)});
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;

`ifdef BCD_COUNTER_MMSS_EN
        add(1, 0, 0, 16'h0100, 16'h0100, 0, 16'h0100, 0);
        add(0, 1, 0, 16'h0000, 16'h0059, 0, 16'h0059, 0);
        add(0, 1, 0, 16'h0000, 16'h0058, 0, 16'h0058, 0);
        add(1, 0, 0, 16'h0077, 16'h0057, 0, 16'h0057, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 1, 16'h5959, 1);
        add(0, 1, 1, 16'h0000, 16'h0001, 0, 16'h0000, 1);
        add(1, 0, 0, 16'h9999, 16'h5959, 0, 16'h5959, 0);
        add(0, 1, 1, 16'h0000, 16'h5959, 1, 16'h0000, 1);
`else
        add(1, 0, 0, 16'h0999, 16'h0999, 0, 16'h0999, 0);
        add(0, 1, 1, 16'h0000, 16'h1000, 0, 16'h1000, 0);
        add(1, 0, 0, 16'h9998, 16'h9998, 0, 16'h9998, 0);
        add(0, 1, 1, 16'h0000, 16'h9999, 1, 16'h9999, 1);
        add(0, 1, 1, 16'h0000, 16'h9999, 0, 16'h0000, 1);
        add(0, 0, 1, 16'h0000, 16'h9999, 0, 16'h0000, 0);
        add(1, 0, 0, 16'h0002, 16'h0002, 0, 16'h0002, 0);
        add(0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h9999, 1);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h9998, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h9997, 0);
        add(1, 1, 1, 16'h0A3F, 16'h0939, 0, 16'h0939, 0);
        add(0, 1, 1, 16'h0000, 16'h0940, 0, 16'h0940, 0);
        add(0, 1, 0, 16'h0000, 16'h0939, 0, 16'h0939, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 1, 16'h9999, 1);
        add(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h9998, 0);
        add(1, 0, 0, 16'h5678, 16'h5678, 0, 16'h5678, 0);
        add(0, 1, 1, 16'h0000, 16'h5679, 0, 16'h5679, 0);
        add(0, 1, 1, 16'h0000, 16'h5680, 0, 16'h5680, 0);
        add(0, 1, 0, 16'h0000, 16'h5679, 0, 16'h5679, 0);
        add(1, 0, 0, 16'hFFFF, 16'h9999, 0, 16'h9999, 0);
`endif

        #1;
        chk_both("reset", 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            load = vecs[i].ld; en = vecs[i].en; up = vecs[i].up; load_val = vecs[i].val;
            @(posedge clk);
            #1;
            $display("vec %0d: load=%0b en=%0b up=%0b val=%h -> hold %h/%0b wrap %h/%0b",
                     i, load, en, up, load_val, count_h, tc_h, count_w, tc_w);
            chk_both($sformatf("vec%0d", i), vecs[i].hc, vecs[i].ht, vecs[i].wc, vecs[i].wt);
        end

        // Asynchronous reset asserted between edges while counting.
        @(negedge clk);
        load = 1'b1; en = 1'b0; load_val = 16'h0123;
        @(posedge clk);
        #1;
        chk_both("preload", 16'h0123, 1'b0, 16'h0123, 1'b0);
        @(negedge clk);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        $display("async reset mid-count -> hold %h/%0b wrap %h/%0b", count_h, tc_h, count_w, tc_w);
        chk_both("async reset", 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        chk_both("reset held", 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        $display("reset release step -> hold %h/%0b wrap %h/%0b", count_h, tc_h, count_w, tc_w);
        chk_both("post reset", 16'h0001, 1'b0, 16'h0001, 1'b0);
        @(negedge clk);
        en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
